// File: rtl/mem_responder.sv
// Memory-side responder for the micro-BESM external bus: single, block and atomic RMW accesses
// to a synchronous RAM. Define MEM_RESPONDER_AUTOINC_EN to enable address auto-increment.
module mem_responder #(
  parameter int AW         = 20,
  parameter int DW         = 64,
  parameter int RD_LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          astb,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic          atomic,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          busy,
  output logic          lock,
  output logic          err,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  logic [AW-1:0]         cur_addr_q, cur_addr_d;
  logic                  addr_ok_q, addr_ok_d;
  logic                  lock_q, lock_d;
  logic                  atomic_q;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  logic          astb_ok, addr_valid, in_flight, viol, rd_acc, wr_acc;
  logic [AW-1:0] eff_addr;

  always_comb begin
    // NOTE: every variable is given a default first, so no path can leave one unassigned.
    astb_ok    = astb & ~lock_q;
    eff_addr   = astb_ok ? addr : cur_addr_q;
    addr_valid = astb_ok | addr_ok_q;
    in_flight  = |pipe_q;
    viol       = (rd & wr) | ((rd | wr) & (in_flight | ~addr_valid));
    rd_acc     = rd & ~wr & ~in_flight & addr_valid;
    wr_acc     = wr & ~rd & ~in_flight & addr_valid;

    cur_addr_d = cur_addr_q;
    addr_ok_d  = addr_ok_q;
    lock_d     = lock_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;

    // A dropped request leaves everything untouched, including an address strobed alongside it.
    if (astb_ok && !viol) begin
      cur_addr_d = addr;
      addr_ok_d  = 1'b1;
    end
`ifdef MEM_RESPONDER_AUTOINC_EN
    // The atomic read keeps the address so the closing write hits the same word.
    if ((rd_acc && !atomic) || wr_acc) begin
      cur_addr_d = eff_addr + AW'(1);
    end
`endif

    if (rd_acc && atomic) begin
      lock_d = 1'b1;
    end else if (wr_acc || (lock_q && atomic_q && !atomic)) begin
      lock_d = 1'b0;
    end

    // Busy blocks new reads, so at most one token is ever in the shift register.
    pipe_d = RD_LATENCY'({pipe_q, rd_acc});
    if (pipe_q[RD_LATENCY-1]) begin
      rdata_d  = ram_rdata;
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      cur_addr_q <= '0;
      addr_ok_q  <= 1'b0;
      lock_q     <= 1'b0;
      atomic_q   <= 1'b0;
      pipe_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      cur_addr_q <= cur_addr_d;
      addr_ok_q  <= addr_ok_d;
      lock_q     <= lock_d;
      atomic_q   <= atomic;
      pipe_q     <= pipe_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q & ~reset;
  assign busy      = in_flight;
  assign lock      = lock_q;
  assign err       = ~reset & ((astb & lock_q) | viol);
  assign ram_en    = ~reset & (rd_acc | wr_acc);
  assign ram_we    = ~reset & wr_acc;
  assign ram_addr  = ram_en ? eff_addr : '0;
  assign ram_wdata = ram_we ? wdata : '0;

endmodule
